alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational 64-bit ALU. Adds OR, set-less-than and the three shifts, and registers the result and flags behind valid/ready on both sides. Sums, logic ops and compares complete in one cycle. Shifts run on an iterative shifter of STEP bits per cycle. Sits between operand fetch and writeback in the integer pipeline and stalls upstream through ready_o.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_core.sv | 72 +++++++
 rtl/alu_seq.sv | 144 ++++++++++++++
 tb/tb_alu_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequenced ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Single-cycle slice: adder with carry/overflow, logic ops and compares.
// Shifts and illegal opcodes return zero here; the top handles shifts.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin_flag,
  output logic [XLEN-1:0] result,
  output logic            cflag,
  output logic            vflag
);

  logic [XLEN-1:0] b_eff;
  logic            cin;
  logic [XLEN:0]   sum;
  logic            add_c;
  logic            add_v;
  logic            add_n;
  logic            c_into_msb;

  // Operand conditioning: subtract-style ops invert B and pick the carry-in.
  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    case (op)
      OP_ADC:                  cin = cin_flag;
      OP_SUB, OP_SLT, OP_SLTU: begin b_eff = ~b; cin = 1'b1;     end
      OP_SBC:                  begin b_eff = ~b; cin = cin_flag; end
      default: ;
    endcase
  end

  assign sum        = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};
  // Carry into the MSB recovered from the MSB sum bit and its two operands.
  assign c_into_msb = a[XLEN-1] ^ b_eff[XLEN-1] ^ sum[XLEN-1];
  assign add_c      = sum[XLEN];
  assign add_v      = add_c ^ c_into_msb;
  assign add_n      = sum[XLEN-1];

  // Result and flag selection per opcode.
  always_comb begin
    result = '0;
    cflag  = 1'b0;
    vflag  = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        result = sum[XLEN-1:0];
        cflag  = add_c;
        vflag  = add_v;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: begin
        result = {{(XLEN-1){1'b0}}, add_n ^ add_v};
        cflag  = add_c;
        vflag  = add_v;
      end
      OP_SLTU: begin
        result = {{(XLEN-1){1'b0}}, ~add_c};
        cflag  = add_c;
        vflag  = add_v;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle arithmetic/logic/compare, iterative shifter,
// registered result and flags held until consumed.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | no result held, ready for a new op
//   S_SHIFT | iterative shift in progress, busy_o high, not ready
//   S_DONE  | result presented on valid_o, ready only if consumed now
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int XLEN = 64,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] inA_i,
  input  logic [XLEN-1:0] inB_i,
  input  logic            cflag_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] out_o,
  output logic            cflag_o,
  output logic            vflag_o,
  output logic            zflag_o,
  output logic            busy_o
);

  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  logic [1:0]      state;
  logic [XLEN-1:0] wreg;
  logic [SHW-1:0]  rem;
  logic [3:0]      sh_op;
  logic            fill;
  logic [XLEN-1:0] out_q;
  logic            c_q;
  logic            v_q;
  logic            z_q;

  logic            accept;
  logic [SHW-1:0]  amt_in;
  logic [XLEN-1:0] core_result;
  logic            core_c;
  logic            core_v;
  logic [SHW:0]    step_amt;
  logic [SHW-1:0]  rem_next;
  logic [XLEN-1:0] shifted;

  alu_seq_core #(.XLEN(XLEN)) u_core (
    .op       (op_i),
    .a        (inA_i),
    .b        (inB_i),
    .cin_flag (cflag_i),
    .result   (core_result),
    .cflag    (core_c),
    .vflag    (core_v)
  );

  assign ready_o = (state == S_IDLE) | ((state == S_DONE) & ready_i);
  assign valid_o = (state == S_DONE);
  assign busy_o  = (state == S_SHIFT);
  assign accept  = valid_i & ready_o;
  assign amt_in  = inB_i[SHW-1:0];

  assign out_o   = out_q;
  assign cflag_o = c_q;
  assign vflag_o = v_q;
  assign zflag_o = z_q;

  // One shifter step: move by min(STEP, remaining); SRA fills with the saved sign.
  always_comb begin
    step_amt = ({1'b0, rem} < STEP_W) ? {1'b0, rem} : STEP_W;
    rem_next = rem - step_amt[SHW-1:0];
    case (sh_op)
      OP_SLL:  shifted = wreg << step_amt;
      OP_SRL:  shifted = wreg >> step_amt;
      OP_SRA:  shifted = (wreg >> step_amt) |
                         (fill ? ~({XLEN{1'b1}} >> step_amt) : {XLEN{1'b0}});
      default: shifted = wreg;
    endcase
  end

  // FSM, shifter working registers and the held result/flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      wreg  <= '0;
      rem   <= '0;
      sh_op <= OP_ADD;
      fill  <= 1'b0;
      out_q <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (is_shift(op_i) && (amt_in != '0)) begin
              state <= S_SHIFT;
              wreg  <= inA_i;
              rem   <= amt_in;
              sh_op <= op_i;
              fill  <= inA_i[XLEN-1];
            end else if (is_shift(op_i)) begin
              // Shift by zero passes A straight through.
              state <= S_DONE;
              out_q <= inA_i;
              c_q   <= 1'b0;
              v_q   <= 1'b0;
              z_q   <= (inA_i == '0);
            end else begin
              state <= S_DONE;
              out_q <= core_result;
              c_q   <= core_c;
              v_q   <= core_v;
              z_q   <= (core_result == '0);
            end
          end else if ((state == S_DONE) && ready_i) begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          wreg <= shifted;
          rem  <= rem_next;
          if (rem_next == '0) begin
            state <= S_DONE;
            out_q <= shifted;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= (shifted == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of model results checked on consume,
// plus explicit latency, backpressure and reset checks.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i, ready_i;
  logic [3:0]      op;
  logic [XLEN-1:0] a, b;
  logic            cin;
  logic            ready_o, valid_o, cf, vf, zf, busy;
  logic [XLEN-1:0] out;
  logic            v8_i, r8_i;
  logic            ready8_o, valid8_o, cf8, vf8, zf8, busy8;
  logic [XLEN-1:0] out8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = 0;
  logic [70:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq #(.XLEN(XLEN), .STEP(1)) dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op), .inA_i(a), .inB_i(b), .cflag_i(cin),
    .valid_o(valid_o), .ready_i(ready_i), .out_o(out),
    .cflag_o(cf), .vflag_o(vf), .zflag_o(zf), .busy_o(busy)
  );

  alu_seq #(.XLEN(XLEN), .STEP(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .valid_i(v8_i), .ready_o(ready8_o),
    .op_i(op), .inA_i(a), .inB_i(b), .cflag_i(cin),
    .valid_o(valid8_o), .ready_i(r8_i), .out_o(out8),
    .cflag_o(cf8), .vflag_o(vf8), .zflag_o(zf8), .busy_o(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: returns {z, v, c, out}.
  function automatic logic [66:0] model(input logic [3:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input logic ci);
    logic [63:0] bb, r;
    logic        c0, c, v;
    logic [64:0] s;
    bb = y; c0 = 1'b0;
    case (o)
      OP_ADC:                  c0 = ci;
      OP_SUB, OP_SLT, OP_SLTU: begin bb = ~y; c0 = 1'b1; end
      OP_SBC:                  begin bb = ~y; c0 = ci;   end
      default: ;
    endcase
    s = {1'b0, x} + {1'b0, bb} + {64'd0, c0};
    c = s[64];
    v = (x[63] == bb[63]) && (s[63] != x[63]);
    case (o)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: r = s[63:0];
      OP_AND:  begin r = x & y; c = 0; v = 0; end
      OP_OR:   begin r = x | y; c = 0; v = 0; end
      OP_XOR:  begin r = x ^ y; c = 0; v = 0; end
      OP_SLT:  r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      OP_SLTU: r = (x < y) ? 64'd1 : 64'd0;
      OP_SLL:  begin r = x << y[5:0]; c = 0; v = 0; end
      OP_SRL:  begin r = x >> y[5:0]; c = 0; v = 0; end
      OP_SRA:  begin r = 64'($signed(x) >>> y[5:0]); c = 0; v = 0; end
      default: begin r = 64'd0; c = 0; v = 0; end
    endcase
    return {(r == 64'd0), v, c, r};
  endfunction

  // Scoreboard consumer: a result is consumed at the posedge after this negedge.
  always @(negedge clk) begin
    if (!reset && valid_o && ready_i) begin
      logic [70:0] e;
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("op%0d_out", e[70:67]), out, e[63:0]);
        check($sformatf("op%0d_c", e[70:67]), 64'(cf), 64'(e[64]));
        check($sformatf("op%0d_v", e[70:67]), 64'(vf), 64'(e[65]));
        check($sformatf("op%0d_z", e[70:67]), 64'(zf), 64'(e[66]));
      end
    end
  end

  // Offer one op on the main DUT; returns at accept edge + 1.
  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic ci, input bit push);
    bit ok = 0;
    op = o; a = x; b = y; cin = ci; valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1; break; end
    end
    check("issue_accept", 64'(ok), 64'd1);
    if (ok && push) sb_q.push_back({o, model(o, x, y, ci)});
    @(posedge clk); #1;
    last_acc = cyc;
    valid_i = 1'b0;
  endtask

  // Cycles from accept edge (counted as 1) until valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, a1, a2, vrise;
    logic [63:0] hold_out;
    logic [3:0] ops[13];
    reset = 1'b1; valid_i = 0; ready_i = 1; v8_i = 0; r8_i = 1;
    op = OP_ADD; a = '0; b = '0; cin = 0;
    idle(2);
    @(negedge clk);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_out",   out, 64'd0);
    check("rst_flags", {61'd0, cf, vf, zf}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADC with all-ones + carry wraps to zero
    issue(OP_ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1);
    wait_valid(lat);
    check("adc_lat", 64'(lat), 64'd1);
    check("adc_out", out, 64'd0);
    check("adc_czv", {61'd0, cf, zf, vf}, 64'b110);

    // SUB overflow, then SLT on the same operands
    issue(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1);
    check("sub_out", out, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_cv",  {62'd0, cf, vf}, 64'b11);
    issue(OP_SLT, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1);
    check("slt_out", out, 64'd1);
    idle(2);

    // SRA by 63, STEP=1
    issue(OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1);
    check("sra_busy", 64'(busy), 64'd1);
    check("sra_ready_busy", 64'(ready_o), 64'd0);
    wait_valid(lat);
    check("sra1_lat", 64'(lat), 64'd64);
    check("sra1_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(2);

    // Same SRA on the STEP=8 instance
    op = OP_SRA; a = 64'h8000_0000_0000_0000; b = 64'd63; cin = 0; v8_i = 1;
    @(negedge clk);
    check("sra8_ready", 64'(ready8_o), 64'd1);
    @(posedge clk); #1;
    v8_i = 0;
    check("sra8_busy", 64'(busy8), 64'd1);
    lat = 1;
    while (!valid8_o && lat < 100) begin @(posedge clk); #1; lat++; end
    check("sra8_lat", 64'(lat), 64'd9);
    check("sra8_out", out8, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sra8_flags", {61'd0, cf8, vf8, zf8}, 64'd0);
    idle(2);

    // Backpressure: result held stable for 5 cycles
    ready_i = 0;
    issue(OP_ADD, 64'd5, 64'd7, 1'b0, 1);
    hold_out = out;
    check("bp_out", hold_out, 64'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", out, hold_out);
      check("bp_ready", 64'(ready_o), 64'd0);
      check("bp_vflags", {60'd0, valid_o, cf, vf, zf}, 64'b1000);
    end
    @(posedge clk); #1;
    ready_i = 1;

    // Streaming logic ops, one per cycle
    issue(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 1'b0, 1);
    a1 = last_acc;
    issue(OP_OR,  64'hF0F0_0000_0000_0001, 64'h0F0F_0000_0000_0000, 1'b0, 1);
    a2 = last_acc;
    check("stream_gap1", 64'(a2 - a1), 64'd1);
    check("stream_valid1", 64'(valid_o), 64'd1);
    issue(OP_XOR, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1);
    check("stream_gap2", 64'(last_acc - a2), 64'd1);
    check("stream_valid2", 64'(valid_o), 64'd1);

    // Illegal opcode
    issue(4'd13, 64'h1234, 64'h5678, 1'b1, 1);
    wait_valid(lat);
    check("ill_lat", 64'(lat), 64'd1);
    check("ill_out", out, 64'd0);
    check("ill_zcv", {61'd0, zf, cf, vf}, 64'b100);
    idle(2);

    // Mixed ops with pseudo-random operands
    ops = '{OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR,
            OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, 4'd14};
    for (int i = 0; i < 26; i++) begin
      logic [3:0] o;
      logic [63:0] x, y;
      o = ops[i % 13];
      x = {$urandom, $urandom};
      y = is_shift(o) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
      if (i == 9) y = 64'd0;
      issue(o, x, y, 1'(i & 1), 1);
      if (is_shift(o)) wait_valid(lat);
    end
    idle(3);

    // Reset in the middle of an SRL by 40
    issue(OP_SRL, 64'hDEAD_BEEF_0000_0001, 64'd40, 1'b0, 0);
    idle(10);
    reset = 1;
    vrise = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (valid_o) vrise++;
      @(posedge clk); #1;
    end
    reset = 0;
    @(negedge clk);
    check("mid_rst_ready", 64'(ready_o), 64'd1);
    check("mid_rst_out", out, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (valid_o) vrise++;
    end
    check("mid_rst_no_valid", 64'(vrise), 64'd0);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
